elevator_car_ctrl: RTL and testbench

- Per-car motion controller for one elevator car; the design instantiates one per car (elv1, elv2).
- Latches hall/cab call buttons and runs a collective up/down scan. Times each floor-to-floor move and the door dwell.
- Produces the 5-bit current-floor number consumed directly by floor_seven_segment (elv1_floor / elv2_floor), plus status flags.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/elevator_car_ctrl_if.sv | 23 ++
 rtl/call_latch.sv | 47 ++++
 rtl/elevator_car_ctrl.sv | 120 ++++++++++++
 tb/tb_elevator_car_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared constants for the elevator car controllers and the floor display side.
package elevator_pkg;

    localparam int unsigned FLOOR_W    = 5;
    localparam int unsigned MAX_FLOORS = 9;

    typedef logic [1:0] car_state_t;

    localparam car_state_t IDLE      = 2'd0;
    localparam car_state_t MOVE_UP   = 2'd1;
    localparam car_state_t MOVE_DOWN = 2'd2;
    localparam car_state_t DOOR_OPEN = 2'd3;

endpackage

// File: rtl/elevator_car_ctrl_if.sv
// Call-button / status bundle between one elevator car controller and its surroundings.
interface elevator_car_ctrl_if #(
    parameter int unsigned NUM_FLOORS = 9
);

    logic [NUM_FLOORS-1:0]            call_btn;
    logic [elevator_pkg::FLOOR_W-1:0] floor;
    logic                             moving;
    logic                             dir_up;
    logic                             door_open;
    logic [NUM_FLOORS-1:0]            pending;

    modport master (
        output call_btn,
        input  floor, moving, dir_up, door_open, pending
    );

    modport slave (
        input  call_btn,
        output floor, moving, dir_up, door_open, pending
    );

endinterface

// File: rtl/call_latch.sv
// Pending-request register with clear-over-set priority and here/above/below reduction
// relative to the current floor.
module call_latch
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] set_i,
    input  logic                  clr_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  set_here_o,
    output logic                  here_o,
    output logic                  above_o,
    output logic                  below_o
);

    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] here_mask;

    always_comb begin
        here_mask = '0;
        above_o   = 1'b0;
        below_o   = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            here_mask[i] = (FLOOR_W'(i + 1) == floor_i);
            if (FLOOR_W'(i + 1) > floor_i) above_o = above_o | pending_q[i];
            if (FLOOR_W'(i + 1) < floor_i) below_o = below_o | pending_q[i];
        end
    end

    assign here_o     = |(pending_q & here_mask);
    assign set_here_o = |(set_i & here_mask);

    // Clear is applied after set so a same-cycle press at the open floor is dropped.
    assign pending_d = (pending_q | set_i) & ~(here_mask & {NUM_FLOORS{clr_i}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/elevator_car_ctrl.sv
// Single-car collective up/down scan controller with floor-travel and door-dwell timing.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = 9,
    parameter int unsigned MOVE_CYCLES = 25000000,
    parameter int unsigned DOOR_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    elevator_car_ctrl_if.slave   bus
);

    localparam int unsigned TIMER_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] BOT_FLOOR = FLOOR_W'(1);

    car_state_t         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               last_up_q, last_up_d;

    logic here, above, below, set_here;

    call_latch #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_call_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (bus.call_btn),
        .clr_i      (state_d == DOOR_OPEN),
        .floor_i    (floor_q),
        .pending_o  (bus.pending),
        .set_here_o (set_here),
        .here_o     (here),
        .above_o    (above),
        .below_o    (below)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TIMER_W'(1);
        floor_d   = floor_q;
        last_up_d = last_up_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (here)       state_d = DOOR_OPEN;
                else if (above) state_d = MOVE_UP;
                else if (below) state_d = MOVE_DOWN;
            end
            MOVE_UP: begin
                last_up_d = 1'b1;
                // A zero timer marks the first cycle at a freshly reached floor.
                if (timer_q == '0 && here) begin
                    state_d = DOOR_OPEN;
                    timer_d = '0;
                end else if (floor_q >= TOP_FLOOR) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == MOVE_LAST) begin
                    floor_d = floor_q + FLOOR_W'(1);
                    timer_d = '0;
                end
            end
            MOVE_DOWN: begin
                last_up_d = 1'b0;
                if (timer_q == '0 && here) begin
                    state_d = DOOR_OPEN;
                    timer_d = '0;
                end else if (floor_q <= BOT_FLOOR) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == MOVE_LAST) begin
                    floor_d = floor_q - FLOOR_W'(1);
                    timer_d = '0;
                end
            end
            DOOR_OPEN: begin
                if (set_here) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    if (last_up_q && above) state_d = MOVE_UP;
                    else if (below)         state_d = MOVE_DOWN;
                    else if (above)         state_d = MOVE_UP;
                    else                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            floor_q   <= BOT_FLOOR;
            last_up_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            floor_q   <= floor_d;
            last_up_q <= last_up_d;
        end
    end

    assign bus.floor     = floor_q;
    assign bus.moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign bus.dir_up    = (state_q == MOVE_UP);
    assign bus.door_open = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed table-driven bench for elevator_car_ctrl with short move/door timing.
module tb_elevator_car_ctrl;

    localparam int unsigned NF = 9;

    typedef struct {
        logic [NF-1:0] btn;
        int            n;
        logic [4:0]    floor;
        logic          mov;
        logic          up;
        logic          door;
        logic [NF-1:0] pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    elevator_car_ctrl_if #(.NUM_FLOORS(NF)) bus ();

    elevator_car_ctrl #(
        .NUM_FLOORS  (NF),
        .MOVE_CYCLES (4),
        .DOOR_CYCLES (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t vecs[64];
    int   nv    = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [NF-1:0] btn, input int n, input int fl, input logic mov,
                       input logic up, input logic door, input logic [NF-1:0] pend);
        vecs[nv].btn   = btn;
        vecs[nv].n     = n;
        vecs[nv].floor = 5'(fl);
        vecs[nv].mov   = mov;
        vecs[nv].up    = up;
        vecs[nv].door  = door;
        vecs[nv].pend  = pend;
        nv++;
    endtask

    task automatic tick(input logic [NF-1:0] btn);
        @(negedge clk);
        bus.call_btn = btn;
        @(posedge clk);
        #1;
        bus.call_btn = '0;
    endtask

    task automatic check(input string name, input int fl, input logic mov, input logic up,
                         input logic door, input logic [NF-1:0] pend);
        logic [16:0] act, exp;
        act = {bus.floor, bus.moving, bus.dir_up, bus.door_open, bus.pending};
        exp = {5'(fl), mov, up, door, pend};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got floor=%0d mov=%b up=%b door=%b pend=%h, want floor=%0d mov=%b up=%b door=%b pend=%h",
                     name, bus.floor, bus.moving, bus.dir_up, bus.door_open, bus.pending,
                     fl, mov, up, door, pend);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.call_btn = '0;

        // Reset / idle.
        add(9'h000, 10, 1, 0, 0, 0, 9'h000);
        // Call floor 3 from floor 1.
        add(9'h004, 1, 1, 0, 0, 0, 9'h004);
        add(9'h000, 1, 1, 1, 1, 0, 9'h004);
        add(9'h000, 4, 2, 1, 1, 0, 9'h004);
        add(9'h000, 4, 3, 1, 1, 0, 9'h004);
        add(9'h000, 1, 3, 0, 0, 1, 9'h000);
        add(9'h000, 5, 3, 0, 0, 1, 9'h000);
        add(9'h000, 1, 3, 0, 0, 0, 9'h000);
        // Floors 5 and 1 together from floor 3: up first.
        add(9'h011, 1, 3, 0, 0, 0, 9'h011);
        add(9'h000, 1, 3, 1, 1, 0, 9'h011);
        add(9'h000, 4, 4, 1, 1, 0, 9'h011);
        add(9'h000, 4, 5, 1, 1, 0, 9'h011);
        add(9'h000, 1, 5, 0, 0, 1, 9'h001);
        add(9'h000, 2, 5, 0, 0, 1, 9'h001);
        // Re-press floor 5 on the third door cycle: dwell restarts, no pending bit.
        add(9'h010, 1, 5, 0, 0, 1, 9'h001);
        add(9'h000, 5, 5, 0, 0, 1, 9'h001);
        add(9'h000, 1, 5, 1, 0, 0, 9'h001);
        add(9'h000, 4, 4, 1, 0, 0, 9'h001);
        add(9'h000, 4, 3, 1, 0, 0, 9'h001);
        add(9'h000, 8, 1, 1, 0, 0, 9'h001);
        add(9'h000, 1, 1, 0, 0, 1, 9'h000);
        add(9'h000, 5, 1, 0, 0, 1, 9'h000);
        add(9'h000, 1, 1, 0, 0, 0, 9'h000);
        // Call at current floor while idle.
        add(9'h001, 1, 1, 0, 0, 0, 9'h001);
        add(9'h000, 1, 1, 0, 0, 1, 9'h000);
        add(9'h000, 5, 1, 0, 0, 1, 9'h000);
        add(9'h000, 1, 1, 0, 0, 0, 9'h000);
        // Full run to the top floor.
        add(9'h100, 1, 1, 0, 0, 0, 9'h100);
        add(9'h000, 1, 1, 1, 1, 0, 9'h100);
        for (int f = 2; f <= 9; f++) add(9'h000, 4, f, 1, 1, 0, 9'h100);
        add(9'h000, 1, 9, 0, 0, 1, 9'h000);
        add(9'h000, 5, 9, 0, 0, 1, 9'h000);
        add(9'h000, 1, 9, 0, 0, 0, 9'h000);
        add(9'h000, 3, 9, 0, 0, 0, 9'h000);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1, 0, 0, 0, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < nv; v++) begin
            tick(vecs[v].btn);
            for (int k = 1; k < vecs[v].n; k++) tick('0);
            check($sformatf("vec%0d", v), vecs[v].floor, vecs[v].mov, vecs[v].up,
                  vecs[v].door, vecs[v].pend);
        end

        // Reset from floor 9, then abort a move between floors 2 and 3.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_from_top", 1, 0, 0, 0, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        tick(9'h010);
        tick('0);
        repeat (4) tick('0);
        repeat (2) tick('0);
        check("mid_move_pre", 2, 1, 1, 0, 9'h010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_abort", 1, 0, 0, 0, 9'h000);
        repeat (3) tick(9'h1ff);
        check("calls_in_reset", 1, 0, 0, 0, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick('0);
        check("after_abort_idle", 1, 0, 0, 0, 9'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
